// File: rtl/cpu_step_seq.sv
// Multi-cycle CPU control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT with single-step and free-run.
// Optional MEM-state watchdog is enabled by defining MEM_TIMEOUT_EN.
module cpu_step_seq #(
  parameter int TMO_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        step_req,
  input  logic [6:0]  op,
  input  logic        dm_ready,
  output logic [2:0]  state,
  output logic        ir_we,
  output logic        rf_we,
  output logic        dm_req,
  output logic        dm_wr,
  output logic        pc_we,
  output logic        busy,
  output logic        err,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q;
  logic        is_store;
  logic        tmo_hit;
  state_e      retire_st;

  assign is_store  = (op == OP_STORE);
  assign retire_st = run_en ? S_FETCH : S_IDLE;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] wait_q;

  // Wait counter restarts on every MEM entry and only advances while memory stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 16'd0;
    end else if (state_q != S_MEM) begin
      wait_q <= 16'd0;
    end else if (!dm_ready) begin
      wait_q <= wait_q + 16'd1;
    end
  end

  assign tmo_hit = (state_q == S_MEM) && (wait_q == 16'(TMO_CYC));
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   if (run_en || step_req) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op == OP_LOAD || op == OP_STORE) begin
          state_d = S_MEM;
        end else if (op == OP_ALU || op == OP_ALUI) begin
          state_d = S_WB;
        end else begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      // A timeout wins over a late dm_ready so the access never retires.
      S_MEM: begin
        if (tmo_hit) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (dm_ready) begin
          state_d = is_store ? retire_st : S_WB;
        end
      end
      S_WB:     state_d = retire_st;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    ir_we  = (state_q == S_FETCH);
    rf_we  = (state_q == S_WB);
    dm_req = (state_q == S_MEM);
    dm_wr  = (state_q == S_MEM) && is_store;
    pc_we  = (state_q == S_WB) ||
             ((state_q == S_MEM) && is_store && dm_ready && !tmo_hit);
    busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_q + {31'd0, pc_we};
    end
  end

  assign state     = state_q;
  assign err       = err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_step_seq.sv
// Self-checking bench for cpu_step_seq: directed scenarios plus random instruction streams
// checked cycle by cycle against an instruction-level expected-state sequence.
module tb_cpu_step_seq;

  localparam int TMO = 16;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst, run_en, step_req, dm_ready;
  logic [6:0]  op;
  logic [2:0]  state;
  logic        ir_we, rf_we, dm_req, dm_wr, pc_we, busy, err;
  logic [31:0] instr_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cycles = 0;
  logic [31:0] mCnt;
  logic        mErr;
  logic [2:0]  mState;

  cpu_step_seq #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req), .op(op),
    .dm_ready(dm_ready), .state(state), .ir_we(ir_we), .rf_we(rf_we),
    .dm_req(dm_req), .dm_wr(dm_wr), .pc_we(pc_we), .busy(busy), .err(err),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: outputs expected from the state the instruction should be in and the driven inputs.
  task automatic clockCycle(input string tag, input logic [2:0] st, input logic isStore);
    logic ir, rf, dq, dw, pc, bz;
    ir = (st == 3'd1);
    rf = (st == 3'd5);
    dq = (st == 3'd4);
    dw = (st == 3'd4) && isStore;
    pc = (st == 3'd5) || ((st == 3'd4) && isStore && dm_ready);
    bz = (st != 3'd0) && (st != 3'd6);
    @(negedge clk);
    checkOutput({tag, "_state"}, 64'(state), 64'(st));
    checkOutput({tag, "_strobes"}, 64'({ir_we, rf_we, dm_req, dm_wr, pc_we, busy, err}),
                64'({ir, rf, dq, dw, pc, bz, mErr}));
    checkOutput({tag, "_cnt"}, 64'(instr_cnt), 64'(mCnt));
    @(posedge clk);
    #1;
    if (pc) mCnt++;
    cycles++;
  endtask

  task automatic randomizeNoise();
    run_en   = 1'($urandom);
    step_req = 1'($urandom);
    dm_ready = 1'($urandom);
  endtask

  // Runs one instruction; waits = dm stall cycles, r = run_en in the retire cycle.
  task automatic applyStimulus(input logic [6:0] opv, input int waits, input logic r, input bit timeout);
    bit isLoad, isStore, isAlu;
    int nMem;
    isLoad  = (opv == OP_LOAD);
    isStore = (opv == OP_STORE);
    isAlu   = (opv == OP_ALU) || (opv == OP_ALUI);
    op = opv;
    if (mState == 3'd0) begin
      run_en   = r;
      step_req = !r;
      dm_ready = 1'($urandom);
      clockCycle("idle", 3'd0, 1'b0);
    end
    randomizeNoise();
    clockCycle("fetch", 3'd1, 1'b0);
    randomizeNoise();
    clockCycle("decode", 3'd2, 1'b0);
    randomizeNoise();
    clockCycle("exec", 3'd3, 1'b0);
    if (!(isLoad || isStore || isAlu)) begin
      mErr   = 1'b1;
      mState = 3'd6;
      return;
    end
    if (isLoad || isStore) begin
      nMem = timeout ? TMO + 1 : waits + 1;
      for (int i = 0; i < nMem; i++) begin
        randomizeNoise();
        dm_ready = !timeout && (i == nMem - 1);
        if (isStore && i == nMem - 1) run_en = r;
        clockCycle("mem", 3'd4, isStore);
      end
      if (timeout) begin
        mErr   = 1'b1;
        mState = 3'd6;
        return;
      end
    end
    if (!isStore) begin
      randomizeNoise();
      run_en = r;
      clockCycle("wb", 3'd5, 1'b0);
    end
    mState = r ? 3'd1 : 3'd0;
  endtask

  task automatic haltCycles(input int n);
    for (int i = 0; i < n; i++) begin
      randomizeNoise();
      op = 7'($urandom);
      clockCycle("halt", 3'd6, 1'b0);
    end
  endtask

  task automatic doReset();
    run_en   = 1'b0;
    step_req = 1'b0;
    dm_ready = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("rst_state", 64'(state), 64'd0);
    checkOutput("rst_flags", 64'({ir_we, rf_we, dm_req, dm_wr, pc_we, busy, err}), 64'd0);
    checkOutput("rst_cnt", 64'(instr_cnt), 64'd0);
    mCnt   = 32'd0;
    mErr   = 1'b0;
    mState = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset lands while a store stalls in MEM; the access must vanish without retiring.
  task automatic resetMidMem();
    op = OP_STORE;
    if (mState == 3'd0) begin
      run_en = 1'b1; step_req = 1'b0; dm_ready = 1'b0;
      clockCycle("rm_idle", 3'd0, 1'b0);
    end
    for (int s = 1; s <= 3; s++) begin
      randomizeNoise();
      clockCycle("rm_pre", 3'(s), 1'b0);
    end
    randomizeNoise();
    dm_ready = 1'b0;
    clockCycle("rm_mem", 3'd4, 1'b1);
    dm_ready = 1'b1;
    #1;
    checkOutput("rm_dmreq_before", 64'(dm_req), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rm_state", 64'(state), 64'd0);
    checkOutput("rm_flags", 64'({dm_req, pc_we, rf_we, err}), 64'd0);
    checkOutput("rm_cnt", 64'(instr_cnt), 64'd0);
    mCnt = 32'd0; mErr = 1'b0; mState = 3'd0;
    run_en = 1'b0; step_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clockCycle("rm_after", 3'd0, 1'b0);
  endtask

  task automatic randomStream(input int n);
    logic [6:0] ops[4];
    ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_ALU; ops[3] = OP_ALUI;
    for (int i = 0; i < n; i++) begin
      applyStimulus(ops[$urandom_range(0, 3)], int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    int start, extra;
    logic [6:0] badOp;
    op = 7'd0;
    doReset();

    applyStimulus(OP_ALU, 0, 1'b0, 1'b0);
    checkOutput("step_alu_cnt", 64'(instr_cnt), 64'd1);

    extra = (mState == 3'd0) ? 1 : 0;
    start = cycles;
    for (int i = 0; i < 3; i++) applyStimulus(OP_LOAD, 0, 1'b1, 1'b0);
    checkOutput("load3_cycles", 64'(cycles - start), 64'(15 + extra));
    checkOutput("load3_cnt", 64'(instr_cnt), 64'd4);

    applyStimulus(OP_STORE, 3, 1'b0, 1'b0);
    randomStream(40);
    resetMidMem();
    randomStream(30);

`ifdef MEM_TIMEOUT_EN
    applyStimulus(OP_LOAD, 0, 1'b1, 1'b1);
    haltCycles(4);
    doReset();
    applyStimulus(OP_STORE, 0, 1'b1, 1'b1);
    haltCycles(3);
    doReset();
`endif

    randomStream(5);
    do badOp = 7'($urandom);
    while (badOp == OP_LOAD || badOp == OP_STORE || badOp == OP_ALU || badOp == OP_ALUI);
    applyStimulus(badOp, 0, 1'b1, 1'b0);
    haltCycles(8);
    doReset();
    applyStimulus(7'b1111111, 0, 1'b0, 1'b0);
    haltCycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_step_seq.md
CPU_STEP_SEQ -- requirements
Module: cpu_step_seq

Interface
REQ-001 Parameter TMO_CYC, default 16: the MEM-state timeout in cycles. It is used only when MEM_TIMEOUT_EN is defined.
REQ-002 clk  input  1: single clock; all state changes on its rising edge.
REQ-003 rst  input  1: asynchronous, active-high reset.
REQ-004 run_en  input  1: level; free-run mode enable.
REQ-005 step_req  input  1: single-step request, sampled only in IDLE.
REQ-006 op  input  7: opcode field of the instruction register.
REQ-007 dm_ready  input  1: data-memory completion strobe, valid only while dm_req=1.
REQ-008 state  output  3: current state encoding.
REQ-009 ir_we  output  1: instruction-register load strobe.
REQ-010 rf_we  output  1: register-file write strobe.
REQ-011 dm_req  output  1: data-memory access request.
REQ-012 dm_wr  output  1: qualifies dm_req as a store.
REQ-013 pc_we  output  1: PC advance strobe; marks instruction retire.
REQ-014 busy  output  1: high in every state except IDLE and HALT.
REQ-015 err  output  1: sticky error flag.
REQ-016 instr_cnt  output  32: count of retired instructions.

Function
REQ-017 States SHALL be encoded as: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is illegal and SHALL go to HALT on the next edge.
REQ-018 IDLE SHALL go to FETCH when run_en=1 or step_req=1; otherwise it stays in IDLE. step_req SHALL be ignored in every other state.
REQ-019 FETCH SHALL assert ir_we for exactly one cycle, then go to DECODE.
REQ-020 DECODE SHALL go to EXEC unconditionally.
REQ-021 EXEC transitions:
- op=0000011 (load) or op=0100011 (store): go to MEM.
- op=0110011 or op=0010011: go to WB.
- any other op: go to HALT and set err.
REQ-022 MEM SHALL hold dm_req=1, and SHALL hold dm_wr=1 when op=0100011. It waits for dm_ready with no limit when MEM_TIMEOUT_EN is undefined.
REQ-023 MEM with dm_ready=1:
- load: go to WB.
- store: assert pc_we that same cycle, then retire.
REQ-024 WB SHALL assert rf_we and pc_we together for exactly one cycle, then retire.
REQ-025 Retire SHALL go to FETCH if run_en=1 in the retire cycle; otherwise it goes to IDLE.
REQ-026 Output strobes SHALL be combinational decodes of state, op and dm_ready. No strobe is active in IDLE or HALT.
REQ-027 instr_cnt SHALL increment by 1 on every cycle where pc_we=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 Cycles per instruction with zero dm wait:
- ALU instruction: 4 (FETCH, DECODE, EXEC, WB).
- Store: 4.
- Load: 5.
- Each dm wait cycle adds 1.
REQ-029 HALT SHALL be absorbing. Only rst exits HALT.
REQ-030 If run_en drops mid-instruction, the instruction SHALL complete and the block SHALL then enter IDLE.

Reset
REQ-031 While rst=1, the following SHALL hold immediately, independent of clk:
- state=IDLE
- err=0
- instr_cnt=0
- all strobes=0
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction with no pc_we and no rf_we.
REQ-033 The first transition after reset deassertion SHALL occur on the first clk edge at which rst=0.

Configuration
REQ-034 Macro MEM_TIMEOUT_EN, when defined:
- A 16-bit wait counter clears on MEM entry.
- The counter increments on each MEM cycle with dm_ready=0.
- When the counter reaches TMO_CYC, the next edge goes to HALT, sets err, and produces no pc_we.
REQ-035 When MEM_TIMEOUT_EN is undefined, no counter logic SHALL exist and MEM waits forever.

Verification
REQ-036 Directed scenarios the bench SHALL cover:
- Step, ALU: run_en=0, step pulse, op=0110011 -> states 1,2,3,5,0; rf_we=pc_we=1 in one cycle; instr_cnt=1.
- Free run, loads: run_en=1, op=0000011, dm_ready at MEM entry, 3 instructions -> 15 cycles; instr_cnt=3; state returns to FETCH after each WB.
- Store with waits: op=0100011, dm_ready after 3 wait cycles -> dm_wr=1 for 4 cycles; pc_we coincident with dm_ready; rf_we never asserted.
- Illegal opcode: op=1111111 -> HALT after EXEC; err=1; step_req and run_en ignored until rst.
- Reset mid-MEM: rst pulsed while dm_req=1 -> immediately state=0, dm_req=0, instr_cnt=0, no pc_we.
- Timeout (MEM_TIMEOUT_EN defined, TMO_CYC=16): dm_ready held 0 -> HALT 17 cycles after MEM entry; err=1.
